capture_scheduler: RTL
======================

Name: capture_scheduler

Overview:
Sequences the PL BRAM capture writer across up to four ADC channels. It latches a PS-written configuration and, for each enabled channel in turn, programs the writer's channel select, start address and length. It then fires the writer's start pulse and waits for its done pulse. It raises one interrupt per completed frame and supports single-shot or continuous ping-pong (bank-alternating) capture, with timeout and abort handling.

Parameters:
NUM_CH, 4, number of capture channels (1..4); mask bits at or above NUM_CH are ignored
SEL_SETTLE, 2, cycles between a channel-select update and the writer start pulse (1..15)
TIMEOUT_CYCLES, 32'd50_000_000, maximum WAIT_DONE cycles before a timeout error
FRAME_CNT_W, 16, width of the frame counter

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous, active-low reset
i_start_pulse  in  1  PS start request, 1-cycle pulse
i_stop_pulse  in  1  graceful stop: finish the current frame, then go IDLE
i_abort_pulse  in  1  immediate abort
i_ch_mask  in  4  enabled channels, bit n = channel n
i_continuous  in  1  1 = loop frames with bank toggle
i_base_addr  in  32  BRAM byte base address
i_stride  in  32  byte distance between capture slots
i_data_len  in  32  samples per channel capture
i_irq_clear_pulse  in  1  clears o_irq and o_err_timeout
i_wr_done_pulse  in  1  done pulse from the BRAM writer
o_wr_start_pulse  out  1  start pulse to the BRAM writer
o_wr_channel_sel  out  32  channel select to the writer, zero-extended channel index
o_wr_start_addr  out  32  start address to the writer
o_wr_data_len  out  32  length to the writer
o_busy  out  1  high whenever state is not IDLE
o_cur_ch  out  2  channel currently being captured
o_bank  out  1  current ping-pong bank
o_frame_done_pulse  out  1  1 cycle at the end of each frame
o_frame_cnt  out  FRAME_CNT_W  completed frames since the last start, wraps
o_irq  out  1  sticky interrupt
o_err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, latched configuration 0.
- States: IDLE, SELECT, SETTLE, ISSUE, WAIT_DONE, FRAME_END.
- IDLE:
  - i_start_pulse with a nonzero effective mask and i_data_len!=0 latches mask, continuous, base, stride and len.
  - Same start also clears o_frame_cnt and o_bank, and selects the lowest enabled channel; next state SELECT.
  - Start with an invalid configuration is ignored: no output change.
- SELECT (1 cycle):
  - Register o_wr_channel_sel = ch, o_cur_ch = ch, o_wr_data_len = len.
  - Register o_wr_start_addr = base + (ch + NUM_CH*bank)*stride, truncated mod 2^32.
  - Next state SETTLE.
- SETTLE: count SEL_SETTLE cycles, then go to ISSUE.
- ISSUE: o_wr_start_pulse=1 for exactly this cycle; clear the timeout counter; next state WAIT_DONE.
- The select, address and length outputs hold stable from SELECT until the next SELECT or IDLE.
- WAIT_DONE:
  - On i_wr_done_pulse, go to SELECT with the next higher enabled channel.
  - If no higher enabled channel exists, go to FRAME_END.
  - Timeout counter increments each cycle; at TIMEOUT_CYCLES, set o_err_timeout and o_irq and go to IDLE.
  - A done pulse in the same cycle as the timeout wins: the timeout does not fire.
- FRAME_END (1 cycle):
  - o_frame_done_pulse=1, o_irq set, o_frame_cnt+1.
  - If continuous and no stop is pending: toggle o_bank, select the lowest enabled channel, go to SELECT.
  - Otherwise go to IDLE.
- i_stop_pulse in any non-IDLE state sets a stop-pending flag. The flag is cleared on entry to IDLE. It is ignored in single-shot mode.
- i_abort_pulse in any state: next cycle IDLE. No frame pulse, no irq, o_wr_start_pulse forced 0; the done pulse of an in-flight capture is ignored. Abort has priority over every other event.
- i_start_pulse while busy: ignored.
- Done pulses outside WAIT_DONE are ignored.
- i_irq_clear_pulse clears o_irq and o_err_timeout. If a set event coincides with a clear, the set wins.
- Latency: start at cycle T gives o_wr_start_pulse at T+2+SEL_SETTLE.
- Configuration inputs are sampled only on an accepted start; changes mid-run have no effect.

Test Plan:
- Mask=4'b0101, base=0x1000, stride=0x400, len=256, single-shot, SEL_SETTLE=2, done returned 10 cycles after each start -> sel=0 with addr 0x1000, then sel=2 with addr 0x1800. First start pulse at T+4. One frame_done, irq=1, frame_cnt=1, then IDLE.
- Continuous, mask=4'b0010, stride=0x100, base=0 -> frames alternate addr 0x100 (bank0) and 0x500 (bank1). A stop pulse mid-frame -> that frame completes, then IDLE with frame_cnt correct.
- Mask=0 or len=0 start -> no start pulse, busy stays 0.
- TIMEOUT_CYCLES=100 with no done -> err_timeout=1 and irq=1 exactly 100 cycles after ISSUE, then IDLE. Clear pulse -> both 0.
- Abort asserted during WAIT_DONE with a done pulse 1 cycle later -> IDLE, no frame pulse, no irq. A restart works normally.
- Async reset asserted mid-SETTLE -> all outputs 0 immediately without a clock. After release, start proceeds from IDLE.

Source files
------------

// File: rtl/capture_scheduler_if.sv
// BRAM capture writer command/response bundle between scheduler (master) and writer (slave).
// Single-cycle start and done pulses; no backpressure, the writer signals completion with done.
interface capture_scheduler_if;
    logic        o_wr_start_pulse;
    logic [31:0] o_wr_channel_sel;
    logic [31:0] o_wr_start_addr;
    logic [31:0] o_wr_data_len;
    logic        i_wr_done_pulse;

    modport master (
        output o_wr_start_pulse, o_wr_channel_sel, o_wr_start_addr, o_wr_data_len,
        input  i_wr_done_pulse
    );
    modport slave (
        input  o_wr_start_pulse, o_wr_channel_sel, o_wr_start_addr, o_wr_data_len,
        output i_wr_done_pulse
    );
endinterface

// File: rtl/capture_scheduler.sv
// Walks enabled ADC channels, programming and firing the BRAM writer; start-to-writer-pulse is 2+SEL_SETTLE cycles.
// No backpressure: each capture waits for the writer done pulse, bounded by TIMEOUT_CYCLES.
module capture_scheduler #(
    parameter int          NUM_CH         = 4,
    parameter int          SEL_SETTLE     = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int          FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start_pulse,
    input  logic                   i_stop_pulse,
    input  logic                   i_abort_pulse,
    input  logic [3:0]             i_ch_mask,
    input  logic                   i_continuous,
    input  logic [31:0]            i_base_addr,
    input  logic [31:0]            i_stride,
    input  logic [31:0]            i_data_len,
    input  logic                   i_irq_clear_pulse,
    capture_scheduler_if.master    wr,
    output logic                   o_busy,
    output logic [1:0]             o_cur_ch,
    output logic                   o_bank,
    output logic                   o_frame_done_pulse,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic                   o_irq,
    output logic                   o_err_timeout
);
    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_ISSUE, S_WAIT_DONE, S_FRAME_END
    } state_t;

    localparam logic [3:0] CH_LIM = 4'((1 << NUM_CH) - 1);

    state_t                 r_state, w_next;
    logic [3:0]             r_mask;
    logic                   r_cont;
    logic [31:0]            r_base, r_stride, r_len;
    logic [1:0]             r_ch;
    logic                   r_bank;
    logic [3:0]             r_settle_cnt;
    logic [31:0]            r_to_cnt;
    logic                   r_stop_pend;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_irq, r_err;
    logic [31:0]            r_sel, r_addr, r_dlen;
    logic [1:0]             r_cur_ch;

    logic [3:0]  w_eff_mask;
    logic [2:0]  w_first, w_lo_r, w_nxt_pick;
    logic [31:0] w_slot;
    logic        w_start_ok, w_frame_end, w_timeout;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] f_pick(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign w_eff_mask = i_ch_mask & CH_LIM;
    assign w_first    = f_pick(w_eff_mask, 3'd0);
    assign w_lo_r     = f_pick(r_mask, 3'd0);
    assign w_nxt_pick = f_pick(r_mask, {1'b0, r_ch} + 3'd1);
    assign w_slot     = 32'(r_ch) + (r_bank ? 32'(NUM_CH) : 32'd0);

    always_comb begin
        w_next      = r_state;
        w_start_ok  = 1'b0;
        w_timeout   = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start_pulse && w_first[2] && (i_data_len != 32'd0)) begin
                    w_start_ok = 1'b1;
                    w_next     = S_SELECT;
                end
            end
            S_SELECT: w_next = S_SETTLE;
            S_SETTLE: if (r_settle_cnt == 4'(SEL_SETTLE - 1)) w_next = S_ISSUE;
            S_ISSUE:  w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (wr.i_wr_done_pulse) begin
                    w_next = w_nxt_pick[2] ? S_SELECT : S_FRAME_END;
                end else if (r_to_cnt >= TIMEOUT_CYCLES - 32'd1) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_FRAME_END: begin
                w_frame_end = 1'b1;
                w_next = (r_cont && !r_stop_pend && !i_stop_pulse && w_lo_r[2]) ? S_SELECT : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Abort overrides every other event, including a coincident done or timeout.
        if (i_abort_pulse) begin
            w_next      = S_IDLE;
            w_start_ok  = 1'b0;
            w_timeout   = 1'b0;
            w_frame_end = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mask       <= 4'd0;
            r_cont       <= 1'b0;
            r_base       <= 32'd0;
            r_stride     <= 32'd0;
            r_len        <= 32'd0;
            r_ch         <= 2'd0;
            r_bank       <= 1'b0;
            r_settle_cnt <= 4'd0;
            r_to_cnt     <= 32'd0;
            r_stop_pend  <= 1'b0;
            r_frame_cnt  <= '0;
            r_irq        <= 1'b0;
            r_err        <= 1'b0;
            r_sel        <= 32'd0;
            r_addr       <= 32'd0;
            r_dlen       <= 32'd0;
            r_cur_ch     <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_mask      <= w_eff_mask;
                r_cont      <= i_continuous;
                r_base      <= i_base_addr;
                r_stride    <= i_stride;
                r_len       <= i_data_len;
                r_frame_cnt <= '0;
                r_bank      <= 1'b0;
                r_ch        <= w_first[1:0];
            end
            if (r_state == S_SELECT) begin
                r_sel        <= 32'(r_ch);
                r_cur_ch     <= r_ch;
                r_dlen       <= r_len;
                r_addr       <= r_base + w_slot * r_stride;
                r_settle_cnt <= 4'd0;
            end else if (r_state == S_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 4'd1;
            end
            // Counter holds the number of cycles elapsed since ISSUE.
            if (r_state == S_ISSUE) r_to_cnt <= 32'd1;
            else if (r_state == S_WAIT_DONE) r_to_cnt <= r_to_cnt + 32'd1;
            if ((r_state == S_WAIT_DONE) && (w_next == S_SELECT)) r_ch <= w_nxt_pick[1:0];
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
                if (w_next == S_SELECT) begin
                    r_bank <= ~r_bank;
                    r_ch   <= w_lo_r[1:0];
                end
            end
            if (w_next == S_IDLE) r_stop_pend <= 1'b0;
            else if ((r_state != S_IDLE) && i_stop_pulse) r_stop_pend <= 1'b1;
            if (w_frame_end || w_timeout) r_irq <= 1'b1;
            else if (i_irq_clear_pulse) r_irq <= 1'b0;
            if (w_timeout) r_err <= 1'b1;
            else if (i_irq_clear_pulse) r_err <= 1'b0;
        end
    end

    assign wr.o_wr_start_pulse = (r_state == S_ISSUE) && !i_abort_pulse;
    assign wr.o_wr_channel_sel = r_sel;
    assign wr.o_wr_start_addr  = r_addr;
    assign wr.o_wr_data_len    = r_dlen;
    assign o_busy              = (r_state != S_IDLE);
    assign o_cur_ch            = r_cur_ch;
    assign o_bank              = r_bank;
    assign o_frame_done_pulse  = w_frame_end;
    assign o_frame_cnt         = r_frame_cnt;
    assign o_irq               = r_irq;
    assign o_err_timeout       = r_err;
endmodule
